// File: rtl/rs_age_ordered.sv
// Age-ordered ALU reservation station: captures operands from the CDB and dispatches the oldest ready entry.
// Optional macro RS_FAST_WAKEUP_EN lets same-cycle broadcasts feed ready/select directly.
module rs_age_ordered #(
   parameter int DEPTH  = 16,
   parameter int CDB_N  = 2,
   parameter int ROB_W  = 4,
   parameter int DATA_W = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rdy,
   input  logic                      rollback,
   output logic                      full,
   input  logic                      issue,
   input  logic [ROB_W-1:0]          issue_rob_pos,
   input  logic [6:0]                issue_opcode,
   input  logic [2:0]                issue_funct3,
   input  logic                      issue_funct7,
   input  logic [DATA_W-1:0]         issue_rs1_val,
   input  logic [DATA_W-1:0]         issue_rs2_val,
   input  logic [ROB_W:0]            issue_rs1_tag,
   input  logic [ROB_W:0]            issue_rs2_tag,
   input  logic [DATA_W-1:0]         issue_imm,
   input  logic [DATA_W-1:0]         issue_pc,
   output logic                      alu_en,
   output logic [6:0]                alu_opcode,
   output logic [2:0]                alu_funct3,
   output logic                      alu_funct7,
   output logic [DATA_W-1:0]         alu_val1,
   output logic [DATA_W-1:0]         alu_val2,
   output logic [DATA_W-1:0]         alu_imm,
   output logic [DATA_W-1:0]         alu_pc,
   output logic [ROB_W-1:0]          alu_rob_pos,
   input  logic [CDB_N-1:0]          cdb_valid,
   input  logic [CDB_N*ROB_W-1:0]    cdb_rob_pos,
   input  logic [CDB_N*DATA_W-1:0]   cdb_val
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int TAG_W = ROB_W + 1;
   localparam int CNT_W = $clog2(DEPTH + 1) + 1;

   logic [DEPTH-1:0]  busy;
   logic [DEPTH-1:0]  older [DEPTH];
   logic [6:0]        e_opcode  [DEPTH];
   logic [2:0]        e_funct3  [DEPTH];
   logic              e_funct7  [DEPTH];
   logic [TAG_W-1:0]  e_tag1    [DEPTH];
   logic [TAG_W-1:0]  e_tag2    [DEPTH];
   logic [DATA_W-1:0] e_val1    [DEPTH];
   logic [DATA_W-1:0] e_val2    [DEPTH];
   logic [DATA_W-1:0] e_imm     [DEPTH];
   logic [DATA_W-1:0] e_pc      [DEPTH];
   logic [ROB_W-1:0]  e_rob_pos [DEPTH];

   logic [TAG_W-1:0]  w_tag1 [DEPTH];
   logic [TAG_W-1:0]  w_tag2 [DEPTH];
   logic [DATA_W-1:0] w_val1 [DEPTH];
   logic [DATA_W-1:0] w_val2 [DEPTH];
   logic [TAG_W-1:0]  i_tag1, i_tag2;
   logic [DATA_W-1:0] i_val1, i_val2;

   logic [DEPTH-1:0]  ready;
   logic              sel_valid;
   logic [IDX_W-1:0]  sel_idx;
   logic              free_valid;
   logic [IDX_W-1:0]  free_idx;
   logic [DEPTH-1:0]  free_mask;
   logic              do_issue;
   logic [DEPTH-1:0]  busy_next;
   logic [CNT_W-1:0]  busy_cnt;
   logic [DATA_W-1:0] disp_val1, disp_val2;

   // Descending scan so the lowest matching channel overrides any higher one.
   function automatic logic [TAG_W+DATA_W-1:0] snoop(
      input logic [TAG_W-1:0]        tag,
      input logic [DATA_W-1:0]       val,
      input logic [CDB_N-1:0]        vld,
      input logic [CDB_N*ROB_W-1:0]  pos,
      input logic [CDB_N*DATA_W-1:0] data
   );
      logic [TAG_W+DATA_W-1:0] res;
      res = {tag, val};
      for (int k = CDB_N - 1; k >= 0; k--) begin
         if (tag[ROB_W] && vld[k] && pos[k*ROB_W +: ROB_W] == tag[ROB_W-1:0])
            res = {1'b0, tag[ROB_W-1:0], data[k*DATA_W +: DATA_W]};
      end
      return res;
   endfunction

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         {w_tag1[i], w_val1[i]} = snoop(e_tag1[i], e_val1[i], cdb_valid, cdb_rob_pos, cdb_val);
         {w_tag2[i], w_val2[i]} = snoop(e_tag2[i], e_val2[i], cdb_valid, cdb_rob_pos, cdb_val);
      end
      {i_tag1, i_val1} = snoop(issue_rs1_tag, issue_rs1_val, cdb_valid, cdb_rob_pos, cdb_val);
      {i_tag2, i_val2} = snoop(issue_rs2_tag, issue_rs2_val, cdb_valid, cdb_rob_pos, cdb_val);
   end

`ifdef RS_FAST_WAKEUP_EN
   always_comb begin
      ready = '0;
      for (int i = 0; i < DEPTH; i++)
         ready[i] = busy[i] && !w_tag1[i][ROB_W] && !w_tag2[i][ROB_W];
   end
   assign disp_val1 = w_val1[sel_idx];
   assign disp_val2 = w_val2[sel_idx];
`else
   always_comb begin
      ready = '0;
      for (int i = 0; i < DEPTH; i++)
         ready[i] = busy[i] && !e_tag1[i][ROB_W] && !e_tag2[i][ROB_W];
   end
   assign disp_val1 = e_val1[sel_idx];
   assign disp_val2 = e_val2[sel_idx];
`endif

   // Exactly one ready entry has no older ready entry, since busy rows form a total order.
   always_comb begin
      sel_valid = 1'b0;
      sel_idx   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ready[i] && (older[i] & ready) == '0) begin
            sel_valid = 1'b1;
            sel_idx   = IDX_W'(i);
         end
      end
   end

   always_comb begin
      free_valid = 1'b0;
      free_idx   = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!busy[i]) begin
            free_valid = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
   end

   always_comb begin
      busy_cnt = '0;
      for (int i = 0; i < DEPTH; i++)
         busy_cnt = busy_cnt + CNT_W'(busy[i]);
   end

   assign full      = (busy_cnt + CNT_W'(issue)) >= CNT_W'(DEPTH);
   assign do_issue  = issue && free_valid;
   assign free_mask = DEPTH'(1) << free_idx;

   always_comb begin
      busy_next = busy;
      if (sel_valid)
         busy_next[sel_idx] = 1'b0;
      if (do_issue)
         busy_next[free_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy        <= '0;
         alu_en      <= 1'b0;
         alu_opcode  <= '0;
         alu_funct3  <= '0;
         alu_funct7  <= 1'b0;
         alu_val1    <= '0;
         alu_val2    <= '0;
         alu_imm     <= '0;
         alu_pc      <= '0;
         alu_rob_pos <= '0;
         for (int i = 0; i < DEPTH; i++)
            older[i] <= '0;
      end else if (rdy) begin
         if (rollback) begin
            busy   <= '0;
            alu_en <= 1'b0;
         end else begin
            for (int i = 0; i < DEPTH; i++) begin
               e_tag1[i] <= w_tag1[i];
               e_val1[i] <= w_val1[i];
               e_tag2[i] <= w_tag2[i];
               e_val2[i] <= w_val2[i];
            end
            alu_en <= sel_valid;
            if (sel_valid) begin
               alu_opcode  <= e_opcode[sel_idx];
               alu_funct3  <= e_funct3[sel_idx];
               alu_funct7  <= e_funct7[sel_idx];
               alu_val1    <= disp_val1;
               alu_val2    <= disp_val2;
               alu_imm     <= e_imm[sel_idx];
               alu_pc      <= e_pc[sel_idx];
               alu_rob_pos <= e_rob_pos[sel_idx];
            end
            busy <= busy_next;
            if (do_issue) begin
               // New entry is younger than every busy one, and nobody is younger than it.
               for (int i = 0; i < DEPTH; i++)
                  older[i] <= (IDX_W'(i) == free_idx) ? busy : (older[i] & ~free_mask);
               e_opcode[free_idx]  <= issue_opcode;
               e_funct3[free_idx]  <= issue_funct3;
               e_funct7[free_idx]  <= issue_funct7;
               e_tag1[free_idx]    <= i_tag1;
               e_val1[free_idx]    <= i_val1;
               e_tag2[free_idx]    <= i_tag2;
               e_val2[free_idx]    <= i_val2;
               e_imm[free_idx]     <= issue_imm;
               e_pc[free_idx]      <= issue_pc;
               e_rob_pos[free_idx] <= issue_rob_pos;
            end
         end
      end
   end

endmodule

// File: tb/tb_rs_age_ordered.sv
// Bench for rs_age_ordered: directed scenarios plus random traffic against a queue-based age model.
module tb_rs_age_ordered;
   localparam int DEPTH  = 16;
   localparam int CDB_N  = 2;
   localparam int ROB_W  = 4;
   localparam int DATA_W = 32;
   localparam int PW     = CDB_N * ROB_W;
   localparam int VW     = CDB_N * DATA_W;
`ifdef RS_FAST_WAKEUP_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic              clk, rst, rdy, rollback, full, issue;
   logic [ROB_W-1:0]  issue_rob_pos;
   logic [6:0]        issue_opcode;
   logic [2:0]        issue_funct3;
   logic              issue_funct7;
   logic [DATA_W-1:0] issue_rs1_val, issue_rs2_val, issue_imm, issue_pc;
   logic [ROB_W:0]    issue_rs1_tag, issue_rs2_tag;
   logic              alu_en;
   logic [6:0]        alu_opcode;
   logic [2:0]        alu_funct3;
   logic              alu_funct7;
   logic [DATA_W-1:0] alu_val1, alu_val2, alu_imm, alu_pc;
   logic [ROB_W-1:0]  alu_rob_pos;
   logic [CDB_N-1:0]  cdb_valid;
   logic [PW-1:0]     cdb_rob_pos;
   logic [VW-1:0]     cdb_val;

   rs_age_ordered #(.DEPTH(DEPTH), .CDB_N(CDB_N), .ROB_W(ROB_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .full(full), .issue(issue),
      .issue_rob_pos(issue_rob_pos), .issue_opcode(issue_opcode), .issue_funct3(issue_funct3),
      .issue_funct7(issue_funct7), .issue_rs1_val(issue_rs1_val), .issue_rs2_val(issue_rs2_val),
      .issue_rs1_tag(issue_rs1_tag), .issue_rs2_tag(issue_rs2_tag), .issue_imm(issue_imm),
      .issue_pc(issue_pc), .alu_en(alu_en), .alu_opcode(alu_opcode), .alu_funct3(alu_funct3),
      .alu_funct7(alu_funct7), .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_imm(alu_imm),
      .alu_pc(alu_pc), .alu_rob_pos(alu_rob_pos), .cdb_valid(cdb_valid),
      .cdb_rob_pos(cdb_rob_pos), .cdb_val(cdb_val)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   bit chk_on = 1'b0;

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: entries kept oldest-first in a queue.
   typedef struct {
      logic [ROB_W:0]    t1, t2;
      logic [DATA_W-1:0] v1, v2, imm, pc;
      logic [6:0]        op;
      logic [2:0]        f3;
      logic              f7;
      logic [ROB_W-1:0]  rob;
   } ent_t;

   ent_t         q[$];
   logic         exp_en = 1'b0;
   logic [159:0] exp_data = '0;
   logic [159:0] dut_data;

   assign dut_data = {17'b0, alu_opcode, alu_funct3, alu_funct7, alu_val1, alu_val2,
                      alu_imm, alu_pc, alu_rob_pos};

   function automatic logic [159:0] pack_out(input ent_t e);
      return {17'b0, e.op, e.f3, e.f7, e.v1, e.v2, e.imm, e.pc, e.rob};
   endfunction

   function automatic logic [ROB_W+DATA_W:0] wake(input logic [ROB_W:0] t, input logic [DATA_W-1:0] v);
      if (t[ROB_W]) begin
         for (int k = 0; k < CDB_N; k++)
            if (cdb_valid[k] && cdb_rob_pos[k*ROB_W +: ROB_W] == t[ROB_W-1:0])
               return {1'b0, t[ROB_W-1:0], cdb_val[k*DATA_W +: DATA_W]};
      end
      return {t, v};
   endfunction

   task automatic model_step();
      ent_t w[$];
      ent_t n, r;
      int   hit, pre;
      if (rst) begin
         q.delete();
         exp_en   = 1'b0;
         exp_data = '0;
         return;
      end
      if (!rdy) return;
      if (rollback) begin
         q.delete();
         exp_en = 1'b0;
         return;
      end
      pre = q.size();
      hit = -1;
      foreach (q[i]) begin
         n = q[i];
         {n.t1, n.v1} = wake(n.t1, n.v1);
         {n.t2, n.v2} = wake(n.t2, n.v2);
         w.push_back(n);
      end
      for (int i = 0; i < pre; i++) begin
         if (FAST) r = w[i];
         else      r = q[i];
         if (hit < 0 && !r.t1[ROB_W] && !r.t2[ROB_W]) hit = i;
      end
      exp_en = (hit >= 0);
      if (hit >= 0) begin
         if (FAST) exp_data = pack_out(w[hit]);
         else      exp_data = pack_out(q[hit]);
         w.delete(hit);
      end
      q = w;
      if (issue && pre < DEPTH) begin
         n.op  = issue_opcode;
         n.f3  = issue_funct3;
         n.f7  = issue_funct7;
         n.imm = issue_imm;
         n.pc  = issue_pc;
         n.rob = issue_rob_pos;
         {n.t1, n.v1} = wake(issue_rs1_tag, issue_rs1_val);
         {n.t2, n.v2} = wake(issue_rs2_tag, issue_rs2_val);
         q.push_back(n);
      end
   endtask

   always @(posedge clk) model_step();

   always @(negedge clk) begin
      if (chk_on) begin
         chk("alu_en", 160'(alu_en), 160'(exp_en));
         chk("full", 160'(full), 160'((q.size() + int'(issue)) >= DEPTH));
         if (exp_en) chk("alu_data", dut_data, exp_data);
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_inputs();
      rdy = 1'b1; rollback = 1'b0; issue = 1'b0;
      issue_rob_pos = '0; issue_opcode = '0; issue_funct3 = '0; issue_funct7 = 1'b0;
      issue_rs1_val = '0; issue_rs2_val = '0; issue_rs1_tag = '0; issue_rs2_tag = '0;
      issue_imm = '0; issue_pc = '0;
      cdb_valid = '0; cdb_rob_pos = '0; cdb_val = '0;
   endtask

   task automatic set_issue(input logic [ROB_W-1:0] rob, input logic [ROB_W:0] t1, input logic [ROB_W:0] t2,
                            input logic [DATA_W-1:0] v1, input logic [DATA_W-1:0] v2);
      issue = 1'b1; issue_rob_pos = rob;
      issue_opcode = 7'h33; issue_funct3 = rob[2:0]; issue_funct7 = rob[0];
      issue_rs1_tag = t1; issue_rs2_tag = t2; issue_rs1_val = v1; issue_rs2_val = v2;
      issue_imm = 32'd100 + DATA_W'(rob); issue_pc = 32'h1000 + 4 * DATA_W'(rob);
   endtask

   task automatic bcast(input int ch, input logic [ROB_W-1:0] rob, input logic [DATA_W-1:0] v);
      cdb_valid[ch] = 1'b1;
      cdb_rob_pos[ch*ROB_W +: ROB_W] = rob;
      cdb_val[ch*DATA_W +: DATA_W] = v;
   endtask

   initial begin
      int gap, pulses;
      int seen[$];
      int at[$];
      idle_inputs();
      rst = 1'b1;
      step();
      chk_on = 1'b1;
      step();
      rst = 1'b0;
      chk("reset_alu_en", 160'(alu_en), 160'(0));
      chk("reset_full", 160'(full), 160'(0));
      chk("reset_alu_val1", 160'(alu_val1), 160'(0));
      chk("reset_alu_rob_pos", 160'(alu_rob_pos), 160'(0));

      // ADD with both operands ready
      set_issue(4'd3, 5'h00, 5'h00, 32'd5, 32'd7);
      step();
      issue = 1'b0;
      chk("add_not_yet", 160'(alu_en), 160'(0));
      step();
      chk("add_en", 160'(alu_en), 160'(1));
      chk("add_val1", 160'(alu_val1), 160'(5));
      chk("add_val2", 160'(alu_val2), 160'(7));
      chk("add_rob", 160'(alu_rob_pos), 160'(3));
      step();
      chk("add_en_drop", 160'(alu_en), 160'(0));

      // older waiting entry, younger ready entry goes first
      set_issue(4'd1, 5'h18, 5'h00, 32'd0, 32'h22);
      step();
      set_issue(4'd2, 5'h00, 5'h00, 32'h10, 32'h20);
      step();
      issue = 1'b0;
      step();
      chk("bypass_first_en", 160'(alu_en), 160'(1));
      chk("bypass_first_rob", 160'(alu_rob_pos), 160'(2));
      bcast(1, 4'd8, 32'h55);
      step();
      cdb_valid = '0;
      gap = 0;
      while (!alu_en && gap < 4) begin
         step();
         gap++;
      end
      chk("wake_gap", 160'(gap), 160'(FAST ? 0 : 1));
      chk("wake_rob", 160'(alu_rob_pos), 160'(1));
      chk("wake_val1", 160'(alu_val1), 160'(32'h55));
      chk("wake_val2", 160'(alu_val2), 160'(32'h22));

      // age order independent of slot index (rob 5 lands in slot 0, below rob 4)
      set_issue(4'd13, 5'h00, 5'h00, 32'd1, 32'd2);
      step();
      set_issue(4'd4, 5'h19, 5'h00, 32'd0, 32'h44);
      step();
      chk("filler_rob", 160'(alu_rob_pos), 160'(13));
      set_issue(4'd5, 5'h19, 5'h00, 32'd0, 32'h45);
      step();
      set_issue(4'd6, 5'h19, 5'h00, 32'd0, 32'h46);
      step();
      issue = 1'b0;
      bcast(0, 4'd9, 32'h99);
      step();
      cdb_valid = '0;
      for (int c = 0; c < 6; c++) begin
         if (alu_en) begin
            seen.push_back(int'(alu_rob_pos));
            at.push_back(c);
         end
         step();
      end
      chk("age_count", 160'(seen.size()), 160'(3));
      if (seen.size() == 3) begin
         chk("age_first", 160'(seen[0]), 160'(4));
         chk("age_second", 160'(seen[1]), 160'(5));
         chk("age_third", 160'(seen[2]), 160'(6));
         chk("age_back_to_back", 160'(at[2] - at[0]), 160'(2));
      end

      // capture on the issue cycle
      set_issue(4'd14, 5'h00, 5'h1A, 32'd1, 32'd0);
      bcast(0, 4'd10, 32'hABCD);
      step();
      issue = 1'b0;
      cdb_valid = '0;
      step();
      chk("cap_en", 160'(alu_en), 160'(1));
      chk("cap_val2", 160'(alu_val2), 160'(32'hABCD));
      chk("cap_rob", 160'(alu_rob_pos), 160'(14));
      step();

      // fill, drop when full, free one, refill
      for (int k = 0; k < DEPTH; k++) begin
         set_issue(ROB_W'(k), {1'b1, ROB_W'(k)}, 5'h00, 32'd0, DATA_W'(k));
         #1;
         if (k == DEPTH - 2) chk("fill_not_full", 160'(full), 160'(0));
         if (k == DEPTH - 1) chk("fill_full_last", 160'(full), 160'(1));
         step();
      end
      issue = 1'b0;
      #1;
      chk("fill_full", 160'(full), 160'(1));
      set_issue(4'd7, 5'h00, 5'h00, 32'd1, 32'd1);
      step();
      issue = 1'b0;
      step();
      chk("fill_drop", 160'(alu_en), 160'(0));
      bcast(0, 4'd3, 32'h33);
      step();
      cdb_valid = '0;
      gap = 0;
      while (!alu_en && gap < 4) begin
         step();
         gap++;
      end
      chk("free_en", 160'(alu_en), 160'(1));
      chk("free_rob", 160'(alu_rob_pos), 160'(3));
      chk("free_full", 160'(full), 160'(0));
      set_issue(4'd5, 5'h00, 5'h00, 32'h5, 32'h6);
      #1;
      chk("refill_full_comb", 160'(full), 160'(1));
      step();
      issue = 1'b0;
      #1;
      chk("refill_full", 160'(full), 160'(1));
      step();
      chk("refill_en", 160'(alu_en), 160'(1));
      chk("refill_rob", 160'(alu_rob_pos), 160'(5));

      // rollback with issue and a ready entry
      bcast(0, 4'd0, 32'h70);
      step();
      cdb_valid = '0;
      rollback = 1'b1;
      bcast(0, 4'd1, 32'h71);
      set_issue(4'd9, 5'h00, 5'h00, 32'd9, 32'd9);
      step();
      rollback = 1'b0;
      issue = 1'b0;
      cdb_valid = '0;
      chk("rb_en", 160'(alu_en), 160'(0));
      #1;
      chk("rb_full", 160'(full), 160'(0));
      pulses = 0;
      for (int k = 0; k < 8; k++) begin
         bcast(0, ROB_W'(2 * k), DATA_W'(k));
         bcast(1, ROB_W'(2 * k + 1), DATA_W'(k));
         step();
         if (alu_en) pulses++;
      end
      cdb_valid = '0;
      step();
      if (alu_en) pulses++;
      chk("rb_empty", 160'(pulses), 160'(0));

      // rdy low freezes everything
      set_issue(4'd2, 5'h00, 5'h00, 32'h12, 32'h13);
      step();
      rdy = 1'b0;
      bcast(0, 4'd1, 32'd1);
      set_issue(4'd3, 5'h00, 5'h00, 32'd1, 32'd1);
      pulses = 0;
      for (int k = 0; k < 3; k++) begin
         step();
         if (alu_en) pulses++;
      end
      chk("hold_no_dispatch", 160'(pulses), 160'(0));
      rdy = 1'b1;
      issue = 1'b0;
      cdb_valid = '0;
      step();
      chk("hold_release_en", 160'(alu_en), 160'(1));
      chk("hold_release_rob", 160'(alu_rob_pos), 160'(2));
      chk("hold_release_val1", 160'(alu_val1), 160'(32'h12));
      step();
      chk("hold_issue_ignored", 160'(alu_en), 160'(0));

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         rst      = ($urandom_range(0, 199) == 0);
         rdy      = ($urandom_range(0, 9) != 0);
         rollback = ($urandom_range(0, 79) == 0);
         issue    = ($urandom_range(0, 2) != 0);
         issue_rob_pos = ROB_W'($urandom_range(0, 15));
         issue_opcode  = 7'($urandom);
         issue_funct3  = 3'($urandom);
         issue_funct7  = 1'($urandom);
         issue_rs1_tag = {1'($urandom_range(0, 1)), ROB_W'($urandom_range(0, 15))};
         issue_rs2_tag = {1'($urandom_range(0, 1)), ROB_W'($urandom_range(0, 15))};
         issue_rs1_val = $urandom;
         issue_rs2_val = $urandom;
         issue_imm     = $urandom;
         issue_pc      = $urandom;
         for (int k = 0; k < CDB_N; k++)
            cdb_valid[k] = ((c / 400) % 2 == 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
         cdb_rob_pos = PW'($urandom);
         cdb_val     = {$urandom, $urandom};
         step();
      end
      idle_inputs();
      rst = 1'b0;
      step();
      step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rs_age_ordered.md
# rs_age_ordered

Parametrised reservation station for the RV32I out-of-order core, sitting between the issue stage and the ALU. It holds DEPTH pending ALU instructions and captures operands from CDB_N result broadcast channels. It dispatches at most one ready instruction per cycle, always choosing the oldest ready entry rather than a fixed slot priority. Wakeup-to-dispatch latency is selectable at compile time.

## Interface
- DEPTH, 16: number of entries; any value ≥ 2, not required to be a power of two.
- CDB_N, 2: number of broadcast channels (ALU, LSB, further units).
- ROB_W, 4: ROB position width; an operand tag is ROB_W+1 bits, with the MSB set meaning pending.
- DATA_W, 32: operand/immediate/PC width.

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global enable; when low, all state and outputs hold.
- rollback  in  1  misprediction flush.
- full  out  1  combinational; high when popcount(busy) + issue ≥ DEPTH.
- issue  in  1  write one entry this cycle.
- issue_rob_pos  in  ROB_W  destination ROB position.
- issue_opcode / issue_funct3 / issue_funct7  in  7/3/1  decoded fields.
- issue_rs1_val, issue_rs2_val  in  DATA_W  operand values, valid when the tag MSB is 0.
- issue_rs1_tag, issue_rs2_tag  in  ROB_W+1  operand tags.
- issue_imm, issue_pc  in  DATA_W  immediate and PC.
- alu_en  out  1  registered dispatch strobe.
- alu_opcode, alu_funct3, alu_funct7, alu_val1, alu_val2, alu_imm, alu_pc, alu_rob_pos  out  matching widths; registered.
- cdb_valid  in  CDB_N  per-channel broadcast valid.
- cdb_rob_pos  in  CDB_N*ROB_W  channel k occupies bits [k*ROB_W +: ROB_W].
- cdb_val  in  CDB_N*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].

## Operation
- Entry state: busy, fields, two tags/values, and an age-matrix row (older[i][j] = entry j was issued before entry i).
- Issue: write to the lowest-index free entry. Set its age row to the current busy vector, and clear column i in all other rows. Issue while all DEPTH entries are busy is a protocol violation; the write is dropped.
- Issue-cycle capture (always present): if an issue tag matches a valid cdb channel in the same cycle, store that value with the tag cleared.
- Wakeup: each edge, every busy entry's pending tag matching any valid channel takes that channel's value and clears its tag. Two channels never carry the same ROB position in one cycle; if they do, the lowest channel index wins.
- Ready: busy and both tags have MSB 0.
- Select: the ready entry i for which no ready entry j has older[i][j] = 1. That entry is dispatched and its busy bit is cleared at the same edge.
- Dispatch and issue to the freed slot may occur in the same cycle. Free-slot selection uses pre-edge busy, so the dispatched slot is reusable from the next cycle.
- rst or rollback: clear all busy bits and drive alu_en to 0. Other fields are don't-care. rollback takes priority over issue, wakeup and dispatch in the same cycle.

## Timing
- Reset values: alu_en = 0, all other alu_* outputs = 0, full = 0 (with issue low).
- Issue at edge N: the entry is visible from cycle N+1. If both operands are ready, alu_en is high after edge N+1.
- alu_en is high for exactly one cycle per dispatch. At most one dispatch per cycle, so throughput is 1/cycle.
- While rdy = 0, nothing updates. Broadcasts and issues presented during that time are ignored; upstream holds them.

## Configuration
- RS_FAST_WAKEUP_EN defined: the ready computation also counts tags matched by current-cycle cdb broadcasts, and the select muxes the broadcast value straight into alu_val1/2. A broadcast at cycle N gives alu_en after edge N (0 extra cycles).
- RS_FAST_WAKEUP_EN undefined: ready uses stored tags only. A broadcast at cycle N gives alu_en after edge N+1.

## Test plan
- Reset, then issue ADD (rob 3, both operands ready, vals 5, 7) -> one cycle later alu_en = 1, val1 = 5, val2 = 7, rob_pos = 3. alu_en is 0 the following cycle.
- Issue rob 1 waiting on tag 0x18 (rob 8), then rob 2 ready. Broadcast rob 8 = 0x55 on channel 1 -> rob 2 dispatches first, then rob 1 with val1 = 0x55. The broadcast-to-dispatch gap is 0 cycles with the macro and 1 without.
- Issue entries rob 4, 5, 6 all waiting on rob 9, then broadcast rob 9 -> dispatch order 4, 5, 6 (oldest first) on consecutive cycles, regardless of slot index.
- Issue with rs2_tag = 0x1A while channel 0 broadcasts rob 10 = 0xABCD -> the entry is ready and later dispatches with val2 = 0xABCD.
- Fill DEPTH entries all waiting -> full = 1 with DEPTH busy. Broadcast to free one -> full drops to 0 after the dispatch edge, and an immediate issue is accepted.
- Rollback asserted together with issue and a ready entry -> alu_en = 0 next cycle, no entries busy, full = 0. Hold rdy = 0 across a broadcast -> state is unchanged.
